// File: rtl/ss_pkg.sv
// Shared definitions for the shadow-stack controller: FSM encodings and
// default sizing constants.
package ss_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PUSH    = 2'd1,
        POP_RD  = 2'd2,
        POP_CMP = 2'd3
    } ss_state_t;

    // 64-entry stack by default
    localparam int SS_DEPTH_LOG2 = 6;
    // OR1K calls return past the delay slot
    localparam int SS_RET_OFFSET = 8;

endpackage

// File: rtl/ss_ram.sv
// Single-port synchronous RAM holding the shadow return addresses.
// One-cycle registered read; no reset so it maps onto block RAM.
module ss_ram #(
    parameter int DEPTH_LOG2 = 6,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Write on we, registered read every cycle (old data on a same-address write)
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/shadow_stack_ctrl.sv
// Shadow-stack sequencer: captures call/return events into one pending slot
// each, pushes return addresses on calls, pops and compares on returns, and
// keeps sticky error flags plus a combined alarm.
module shadow_stack_ctrl
    import ss_pkg::*;
#(
    parameter int DEPTH_LOG2 = SS_DEPTH_LOG2,
    parameter int ADDR_W     = 32,
    parameter int RET_OFFSET = SS_RET_OFFSET
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  jal_i,
    input  logic [ADDR_W-1:0]     jal_pc_i,
    input  logic                  jr_i,
    input  logic [ADDR_W-1:0]     jr_target_i,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic [DEPTH_LOG2:0]   depth_o,
    output logic                  alarm_o,
    output logic                  mismatch_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  lost_o,
    output logic [ADDR_W-1:0]     bad_addr_o
);

    localparam logic [DEPTH_LOG2:0] SP_ONE  = 1;
    localparam logic [ADDR_W-1:0]   RET_ADD = ADDR_W'(RET_OFFSET);

    ss_state_t             state_reg, state_next;
    logic [DEPTH_LOG2:0]   sp_reg, sp_next, sp_dec;
    logic                  pend_jal_reg, pend_jr_reg;
    logic [ADDR_W-1:0]     pend_ret_reg, pend_tgt_reg;
    logic                  mismatch_reg, overflow_reg, underflow_reg, lost_reg, alarm_reg;
    logic                  mismatch_next, overflow_next, underflow_next, lost_next;
    logic [ADDR_W-1:0]     bad_addr_reg;

    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [ADDR_W-1:0]     ram_rdata;

    logic jal_done, jr_done;
    logic ovf_evt, unf_evt, mis_evt, lost_evt;
    logic jal_acc, jr_acc, jal_take, jr_take;

    ss_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (pend_ret_reg),
        .rdata (ram_rdata)
    );

    assign sp_dec = sp_reg - SP_ONE;

    // Events are accepted when the slot is empty or being drained this cycle
    assign jal_acc  = enable_i & jal_i;
    assign jr_acc   = enable_i & jr_i;
    assign jal_take = jal_acc & (~pend_jal_reg | jal_done);
    assign jr_take  = jr_acc  & (~pend_jr_reg  | jr_done);
    assign lost_evt = (jal_acc & ~jal_take) | (jr_acc & ~jr_take);

    // Sticky flags: a new error in the same cycle as clear_i keeps the flag set
    assign mismatch_next  = (mismatch_reg  & ~clear_i) | mis_evt;
    assign overflow_next  = (overflow_reg  & ~clear_i) | ovf_evt;
    assign underflow_next = (underflow_reg & ~clear_i) | unf_evt;
    assign lost_next      = (lost_reg      & ~clear_i) | lost_evt;

    // Next-state, RAM control and error-event decode
    always_comb begin
        state_next = state_reg;
        sp_next    = sp_reg;
        ram_we     = 1'b0;
        ram_addr   = sp_reg[DEPTH_LOG2-1:0];
        jal_done   = 1'b0;
        jr_done    = 1'b0;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        mis_evt    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pend_jal_reg) begin
                    state_next = PUSH;
                end else if (pend_jr_reg) begin
                    state_next = POP_RD;
                end
            end
            PUSH: begin
                jal_done = 1'b1;
                // Top bit of sp set means the stack holds DEPTH entries
                if (!sp_reg[DEPTH_LOG2]) begin
                    ram_we  = 1'b1;
                    sp_next = sp_reg + SP_ONE;
                end else begin
                    ovf_evt = 1'b1;
                end
                state_next = IDLE;
            end
            POP_RD: begin
                if (sp_reg == '0) begin
                    unf_evt    = 1'b1;
                    jr_done    = 1'b1;
                    state_next = IDLE;
                end else begin
                    ram_addr   = sp_dec[DEPTH_LOG2-1:0];
                    state_next = POP_CMP;
                end
            end
            POP_CMP: begin
                mis_evt    = (ram_rdata != pend_tgt_reg);
                sp_next    = sp_dec;
                jr_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, stack pointer and pending event slots
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            sp_reg       <= '0;
            pend_jal_reg <= 1'b0;
            pend_jr_reg  <= 1'b0;
            pend_ret_reg <= '0;
            pend_tgt_reg <= '0;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
            if (jal_take) begin
                pend_jal_reg <= 1'b1;
                pend_ret_reg <= jal_pc_i + RET_ADD;
            end else if (jal_done) begin
                pend_jal_reg <= 1'b0;
            end
            if (jr_take) begin
                pend_jr_reg  <= 1'b1;
                pend_tgt_reg <= jr_target_i;
            end else if (jr_done) begin
                pend_jr_reg <= 1'b0;
            end
        end
    end

    // Sticky error flags, registered alarm and first-mismatch capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            lost_reg      <= 1'b0;
            alarm_reg     <= 1'b0;
            bad_addr_reg  <= '0;
        end else begin
            mismatch_reg  <= mismatch_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            lost_reg      <= lost_next;
            alarm_reg     <= mismatch_next | overflow_next | underflow_next | lost_next;
            if (mis_evt && !mismatch_reg) begin
                bad_addr_reg <= ram_rdata;
            end
        end
    end

    assign busy_o      = (state_reg != IDLE) | pend_jal_reg | pend_jr_reg;
    assign depth_o     = sp_reg;
    assign alarm_o     = alarm_reg;
    assign mismatch_o  = mismatch_reg;
    assign overflow_o  = overflow_reg;
    assign underflow_o = underflow_reg;
    assign lost_o      = lost_reg;
    assign bad_addr_o  = bad_addr_reg;

endmodule
